// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: drives datapath controls, captures product.
// Optional MULT_FAST_SKIP_EN skips the ADD cycle for 00/11 Booth pairs.
package mult_booth_pkg;
    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;
endpackage

module mult_booth_ctrl
    import mult_booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          start_ready,
    input  logic [N-1:0]  A_in,
    input  logic [N-1:0]  B_in,
    output logic [N-1:0]  A,
    output logic [N-1:0]  B,
    output logic          dp_clr,
    output mult_control_t mult_control,
    input  logic [1:0]    Q_LSB,
    input  logic [2*N-1:0] Y,
    output logic [2*N-1:0] product,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          busy
);
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, EVAL, ADD, SHIFT, CAPTURE, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    op;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            A            <= '0;
            B            <= '0;
            cnt          <= '0;
            op           <= '0;
            product      <= '0;
            result_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        A   <= A_in;
                        B   <= B_in;
                        cnt <= '0;
                    end
                end
                EVAL:  op  <= Q_LSB;
                SHIFT: cnt <= cnt + 1'b1;
                CAPTURE: begin
                    product      <= Y;
                    result_valid <= 1'b1;
                end
                DONE: begin
                    if (result_ready)
                        result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Controls decode only from registered state/op, so they cannot glitch.
    always_comb begin
        state_nxt            = state;
        mult_control         = '0;
        mult_control.add_sub = (state != IDLE);
        dp_clr               = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                dp_clr    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                mult_control.load_A = 1'b1;
                mult_control.load_B = 1'b1;
                state_nxt           = EVAL;
            end
            EVAL: begin
`ifdef MULT_FAST_SKIP_EN
                state_nxt = (Q_LSB[1] ^ Q_LSB[0]) ? ADD : SHIFT;
`else
                state_nxt = ADD;
`endif
            end
            ADD: begin
                unique case (1'b1)
                    (op == 2'b01): begin
                        mult_control.load_add = 1'b1;
                        mult_control.add_sub  = 1'b1;
                    end
                    (op == 2'b10): begin
                        mult_control.load_add = 1'b1;
                        mult_control.add_sub  = 1'b0;
                    end
                    default: ;
                endcase
                state_nxt = SHIFT;
            end
            SHIFT: begin
                mult_control.shift_HQ_LQ_Q_1 = 1'b1;
                state_nxt = (cnt == CW'(N - 1)) ? CAPTURE : EVAL;
            end
            CAPTURE: state_nxt = DONE;
            DONE: begin
                if (result_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Directed bench for mult_booth_ctrl with a behavioural Booth datapath model.
// Expected latencies follow MULT_FAST_SKIP_EN when it is defined.
module tb_mult_booth_ctrl;
    import mult_booth_pkg::*;

    localparam int N = 8;
`ifdef MULT_FAST_SKIP_EN
    localparam int L_3X5  = 23;
    localparam int L_ZERO = 19;
    localparam int L_2XM4 = 20;
    localparam int L_B2B1 = 23;
`else
    localparam int L_3X5  = 27;
    localparam int L_ZERO = 27;
    localparam int L_2XM4 = 27;
    localparam int L_B2B1 = 27;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          start_ready;
    logic [N-1:0]  A_in = '0;
    logic [N-1:0]  B_in = '0;
    logic [N-1:0]  A, B;
    logic          dp_clr;
    mult_control_t mult_control;
    logic [1:0]    Q_LSB;
    logic [2*N-1:0] Y;
    logic [2*N-1:0] product;
    logic          result_valid;
    logic          result_ready = 1'b1;
    logic          busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int la_cnt = 0;
    int inv_cnt = 0;

    mult_booth_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .start(start), .start_ready(start_ready),
        .A_in(A_in), .B_in(B_in), .A(A), .B(B),
        .dp_clr(dp_clr), .mult_control(mult_control),
        .Q_LSB(Q_LSB), .Y(Y), .product(product),
        .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model; one guard bit on HQ keeps -2^(N-1) * -2^(N-1) exact.
    logic [N:0]   hq = '0;
    logic [N-1:0] lq = '0;
    logic [N-1:0] am = '0;
    logic         q1 = 1'b0;
    assign Q_LSB = {lq[0], q1};
    assign Y     = {hq[N-1:0], lq};

    always @(posedge clk) begin
        if (dp_clr) begin
            hq <= '0; lq <= '0; am <= '0; q1 <= 1'b0;
        end else begin
            if (mult_control.load_A) am <= A;
            if (mult_control.load_B) lq <= B;
            if (mult_control.load_add)
                hq <= mult_control.add_sub ? hq + {am[N-1], am}
                                           : hq - {am[N-1], am};
            if (mult_control.shift_HQ_LQ_Q_1) begin
                hq <= {hq[N], hq[N:1]};
                lq <= {hq[0], lq[N-1:1]};
                q1 <= lq[0];
            end
        end
    end

    always @(negedge clk) begin
        if (mult_control.load_add) la_cnt <= la_cnt + 1;
        if (mult_control.load_add && mult_control.shift_HQ_LQ_Q_1)
            inv_cnt <= inv_cnt + 1;
    end

    // Issue one request and wait for result_valid; lat=-1 on timeout.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output logic [2*N-1:0] p,
                         output logic b0);
        int t0, n;
        @(negedge clk);
        A_in = a; B_in = b; start = 1'b1;
        @(negedge clk);
        t0 = cyc; b0 = busy;
        start = 1'b0; A_in = 8'hAA; B_in = 8'h55;
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = (result_valid === 1'b1) ? cyc - t0 : -1;
        p = product;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (start_ready !== 1'b1) begin nerr++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (result_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        nvec++; if (product !== 16'h0) begin nerr++; $display("FAIL reset_product: got %h want 0000", product); end
        nvec++; if (A !== 8'h0 || B !== 8'h0) begin nerr++; $display("FAIL reset_AB: got %h %h want 00 00", A, B); end
        nvec++; if (mult_control !== 5'b0) begin nerr++; $display("FAIL reset_ctrl: got %b want 00000", mult_control); end
        nvec++; if (dp_clr !== 1'b0) begin nerr++; $display("FAIL reset_dp_clr: got %b want 0", dp_clr); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_positive();
        int lat; logic [2*N-1:0] p; logic b0; int la0;
        result_ready = 1'b1;
        la0 = la_cnt;
        do_op(8'd3, 8'd5, lat, p, b0);
        nvec++; if (p !== 16'h000F) begin nerr++; $display("FAIL pos_product: got %h want 000f", p); end
        nvec++; if (lat !== L_3X5) begin nerr++; $display("FAIL pos_latency: got %0d want %0d", lat, L_3X5); end
        nvec++; if (b0 !== 1'b1) begin nerr++; $display("FAIL pos_busy_edge0: got %b want 1", b0); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL pos_busy_done: got %b want 1", busy); end
        @(negedge clk);
        nvec++; if (busy !== 1'b0 || start_ready !== 1'b1) begin nerr++; $display("FAIL pos_idle: got busy=%b rdy=%b want 0 1", busy, start_ready); end
        nvec++; if (result_valid !== 1'b0) begin nerr++; $display("FAIL pos_valid_clr: got %b want 0", result_valid); end
        nvec++; if (la_cnt == la0) begin nerr++; $display("FAIL pos_load_add: got %0d adds want >0", la_cnt - la0); end
    endtask

    task automatic test_signed();
        int lat; logic [2*N-1:0] p; logic b0;
        do_op(8'hFD, 8'd5, lat, p, b0);
        nvec++; if (p !== 16'hFFF1) begin nerr++; $display("FAIL neg_product: got %h want fff1", p); end
        do_op(8'h80, 8'h80, lat, p, b0);
        nvec++; if (p !== 16'h4000) begin nerr++; $display("FAIL extreme_product: got %h want 4000", p); end
        @(negedge clk);
    endtask

    task automatic test_zero_mult();
        int lat; logic [2*N-1:0] p; logic b0; int la0;
        la0 = la_cnt;
        do_op(8'h7F, 8'h00, lat, p, b0);
        @(negedge clk);
        nvec++; if (p !== 16'h0) begin nerr++; $display("FAIL zero_product: got %h want 0000", p); end
        nvec++; if (lat !== L_ZERO) begin nerr++; $display("FAIL zero_latency: got %0d want %0d", lat, L_ZERO); end
        nvec++; if (la_cnt !== la0) begin nerr++; $display("FAIL zero_load_add: got %0d adds want 0", la_cnt - la0); end
    endtask

    task automatic test_backpressure();
        int n;
        result_ready = 1'b0;
        @(negedge clk);
        A_in = 8'h0B; B_in = 8'h03; start = 1'b1;
        @(negedge clk);
        A_in = 8'h01; B_in = 8'h01;
        repeat (4) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvec++; if (result_valid !== 1'b1) begin nerr++; $display("FAIL bp_timeout: got valid=%b want 1", result_valid); end
        nvec++; if (product !== 16'h0021) begin nerr++; $display("FAIL bp_product: got %h want 0021", product); end
        start = 1'b1; A_in = 8'h09; B_in = 8'h09;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (product !== 16'h0021 || result_valid !== 1'b1 || start_ready !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold%0d: got p=%h v=%b rdy=%b want 0021 1 0", i, product, result_valid, start_ready);
            end
        end
        start = 1'b0; result_ready = 1'b1;
        @(negedge clk);
        nvec++; if (result_valid !== 1'b0 || start_ready !== 1'b1) begin nerr++; $display("FAIL bp_release: got v=%b rdy=%b want 0 1", result_valid, start_ready); end
    endtask

    task automatic test_reset_midop();
        int t0, lat; logic [2*N-1:0] p; logic b0;
        @(negedge clk);
        A_in = 8'd7; B_in = 8'd9; start = 1'b1;
        @(negedge clk);
        t0 = cyc; start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || A !== 8'h0 || B !== 8'h0 ||
            product !== 16'h0 || result_valid !== 1'b0 || mult_control !== 5'b0 || dp_clr !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_outputs: got busy=%b rdy=%b A=%h B=%h p=%h v=%b ctl=%b clr=%b want all 0, rdy 1",
                     busy, start_ready, A, B, product, result_valid, mult_control, dp_clr);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(8'd2, 8'hFC, lat, p, b0);
        nvec++; if (p !== 16'hFFF8) begin nerr++; $display("FAIL midrst_product: got %h want fff8", p); end
        nvec++; if (lat !== L_2XM4) begin nerr++; $display("FAIL midrst_latency: got %0d want %0d", lat, L_2XM4); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t0, t1, n;
        logic [2*N-1:0] p1;
        result_ready = 1'b1;
        @(negedge clk);
        A_in = 8'h12; B_in = 8'h0A; start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        A_in = 8'h05; B_in = 8'hF9;
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        p1 = product;
        nvec++; if (p1 !== 16'h00B4) begin nerr++; $display("FAIL b2b_product1: got %h want 00b4", p1); end
        nvec++; if (cyc - t0 !== L_B2B1) begin nerr++; $display("FAIL b2b_latency1: got %0d want %0d", cyc - t0, L_B2B1); end
        n = 0;
        while (start_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        t1 = cyc;
        start = 1'b0; A_in = 8'hAA; B_in = 8'h55;
        nvec++; if (t1 - t0 !== L_B2B1 + 2 || busy !== 1'b1) begin nerr++; $display("FAIL b2b_gap: got %0d busy=%b want %0d 1", t1 - t0, busy, L_B2B1 + 2); end
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvec++; if (product !== 16'hFFDD || result_valid !== 1'b1) begin nerr++; $display("FAIL b2b_product2: got %h v=%b want ffdd 1", product, result_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_positive();
        test_signed();
        test_zero_mult();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        nvec++; if (inv_cnt !== 0) begin nerr++; $display("FAIL add_shift_overlap: got %0d cycles want 0", inv_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mult_booth_ctrl.md
Name: mult_booth_ctrl

Overview:
- Sequencing controller for the radix-2 Booth multiplier datapath. It drives the datapath's `mult_control_t` control struct and its synchronous clear.
- Reads back the `Q_LSB` pair and the `Y` product. Runs N add/sub-and-shift iterations per operation.
- Provides a start/ready request handshake and a valid/ready result handshake, so the multiplier can sit behind a bus-side requester.

Parameters:
- N, 8, operand width in bits. Must match the datapath instance N. Legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request strobe; accepted only when start_ready=1
- start_ready  output  1  high when state is IDLE
- A_in  input  N  multiplicand, sampled with an accepted start; forwarded to the datapath A
- B_in  input  N  multiplier, sampled with an accepted start; forwarded to the datapath B
- A  output  N  registered multiplicand to the datapath
- B  output  N  registered multiplier to the datapath
- dp_clr  output  1  active-high synchronous clear to the datapath rst
- mult_control  output  5 (`mult_control_t`)  {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}
- Q_LSB  input  2  {LQ[0], Q_1} from the datapath
- Y  input  2N  {HQ, LQ} from the datapath
- product  output  2N  captured signed product
- result_valid  output  1  product is valid
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous): state=IDLE; A=0; B=0; product=0; result_valid=0; all mult_control fields=0; dp_clr=0; busy=0; iteration counter=0.
- Outputs mult_control and dp_clr are combinational decodes of the state and the op register. They are glitch-free with respect to clk.
- Default field values in any state not listed below: load_A=0, load_B=0, load_add=0, shift_HQ_LQ_Q_1=0, add_sub=1, dp_clr=0.
- FSM states and transitions:
  - IDLE: if start=1, latch A_in→A and B_in→B, counter←0, go to CLEAR. Otherwise stay.
  - CLEAR: dp_clr=1. Go to LOAD.
  - LOAD: load_A=1 and load_B=1. Go to EVAL.
  - EVAL: latch Q_LSB into the 2-bit op register. Go to ADD.
  - ADD: for op=01, load_add=1 and add_sub=1 (add). For op=10, load_add=1 and add_sub=0 (subtract). For op=00 or 11, no control asserted. Go to SHIFT.
  - SHIFT: shift_HQ_LQ_Q_1=1, counter←counter+1. If counter==N-1, go to CAPTURE; else go to EVAL.
  - CAPTURE: product←Y, result_valid←1. Go to DONE.
  - DONE: hold product and result_valid. When result_ready=1, clear result_valid and go to IDLE.
- Invariants:
  - load_add and shift_HQ_LQ_Q_1 are never high in the same cycle.
  - load_A and load_B are high only in LOAD.
- Latency (default build):
  - Take the edge that samples start as edge 0. result_valid rises at edge 3N+3 (27 for N=8).
  - A consumer holding result_ready=1 ends DONE on the first cycle, so the next start is accepted at edge 3N+5.
- Counter width: $clog2(N). It wraps only through the IDLE reload; no overflow is otherwise reachable.
- Boundary conditions:
  - start while busy=1 is ignored; no queueing.
  - start and result_ready high together in DONE: the start is ignored, because start_ready=0 in DONE.
  - result_ready high outside DONE has no effect.
  - Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The datapath is re-cleared by the next CLEAR state.
  - A_in/B_in changing after acceptance has no effect.

Optional Feature:
- Macro: MULT_FAST_SKIP_EN.
- Defined: EVAL decodes Q_LSB directly.
  - op=00 or 11: go straight to SHIFT, skipping ADD.
  - op=01 or 10: go to ADD as normal.
  - Latency becomes 2N + (number of 01/10 pairs) + 3 edges.
- Undefined: fixed 3 cycles per iteration, constant latency 3N+3.

Test Plan:
- Positive operands: A_in=3, B_in=5, result_ready=1 → product=16'h000F, result_valid at edge 27, busy high from edge 0 to edge 28.
- Signed multiplicand and both-negative extreme:
  - A_in=-3 (8'hFD), B_in=5 → product=16'hFFF1.
  - A_in=8'h80, B_in=8'h80 → product=16'h4000.
- Zero multiplier: A_in=8'h7F, B_in=0 → product=0.
  - Default build: mult_control.load_add never asserted; latency 27.
  - With MULT_FAST_SKIP_EN: latency 19.
- Backpressure: result_ready held low 5 cycles after result_valid → product and result_valid stable; start pulses during DONE ignored (start_ready=0); handshake completes on result_ready=1.
- Reset mid-operation: rst low at edge 10 of A_in=7, B_in=9 → all outputs 0 and state IDLE; a new request A_in=2, B_in=-4 then yields product=16'hFFF8.
- Back-to-back: two requests with result_ready=1 → second start accepted 3N+5 edges after the first; products correct for both.
